// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default timing constants.
// Used by the TX controller and intended for reuse by the RX controller.
package uart_pkg;

    localparam int unsigned SB_TICK_DEF  = 16;   // baud ticks per bit
    localparam int unsigned DVSR_RST_DEF = 650;  // divisor after reset
    localparam int unsigned DVSR_W       = 16;   // divisor register width

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_tx_shift.sv
// Transmit data path: loads the byte and its parity bit at the handshake,
// shifts right at each data-bit boundary.
// Ports:
//   load       - capture data_in and compute the parity bit
//   shift      - move to the next data bit (LSB first)
//   data_in    - byte to send
//   par_odd    - 1 = odd parity, 0 = even, sampled on load
//   lsb_next_c - data bit the line carries after this edge
//   par_bit    - parity bit of the loaded byte (registered)
module uart_tx_shift #(
    parameter int unsigned DBIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            shift,
    input  logic [DBIT-1:0] data_in,
    input  logic            par_odd,
    output logic            lsb_next_c,
    output logic            par_bit
);

    logic [DBIT-1:0] shreg_q, shreg_d;
    logic            par_q, par_d;

    // Load has priority; shifting only happens while a frame is active.
    always_comb begin
        shreg_d = shreg_q;
        par_d   = par_q;
        if (load) begin
            shreg_d = data_in;
            par_d   = (^data_in) ^ par_odd;
        end else if (shift) begin
            shreg_d = {1'b0, shreg_q[DBIT-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            par_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            par_q   <= par_d;
        end
    end

    // Lets the controller register tx on the same edge the shift happens.
    assign lsb_next_c = shift ? shreg_q[1] : shreg_q[0];
    assign par_bit    = par_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller. Owns the baud divisor and baud_gen enable,
// accepts bytes over valid/ready and serialises start/data/parity/stop.
// Ports:
//   cfg_dvsr/cfg_wr/cfg_err - divisor write; rejected with a pulse when busy
//   dvsr/baud_en/baud_tick  - interface to the external baud_gen
//   par_en/par_odd          - parity options, sampled at handshake
//   tx_data/tx_valid/tx_ready - byte handshake, ready only in IDLE
//   tx_done                 - one-cycle pulse at end of the last stop bit
//   tx                      - serial line, idle high
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DBIT      = 8,
    parameter int unsigned SB_TICK   = SB_TICK_DEF,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned DVSR_RST  = DVSR_RST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DVSR_W-1:0] cfg_dvsr,
    input  logic              cfg_wr,
    output logic              cfg_err,
    output logic [DVSR_W-1:0] dvsr,
    output logic              baud_en,
    input  logic              baud_tick,
    input  logic              par_en,
    input  logic              par_odd,
    input  logic [DBIT-1:0]   tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_done,
    output logic              tx
);

    localparam int unsigned S_W   = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
    localparam int unsigned N_MAX = (DBIT > STOP_BITS) ? DBIT : STOP_BITS;
    localparam int unsigned N_W   = (N_MAX > 1) ? $clog2(N_MAX) : 1;

    uart_state_e       state_q, state_d;
    logic [S_W-1:0]    s_q, s_d;
    logic [N_W-1:0]    n_q, n_d;
    logic              tx_q, tx_d;
    logic              tx_ready_q, tx_ready_d;
    logic              baud_en_q, baud_en_d;
    logic              en_prev_q;
    logic              tx_done_q, tx_done_d;
    logic              cfg_err_q, cfg_err_d;
    logic [DVSR_W-1:0] dvsr_q, dvsr_d;
    logic              par_en_q, par_en_d;

    logic tick_c, bit_end_c, load_c, shift_c, lsb_next_c, par_bit;

    // baud_gen holds a stale tick level while disabled, so a tick only
    // counts when it was produced under an enable from the previous cycle.
    assign tick_c    = baud_tick & en_prev_q;
    assign bit_end_c = tick_c && (s_q == S_W'(SB_TICK - 1));
    assign load_c    = (state_q == ST_IDLE) && tx_valid;
    assign shift_c   = (state_q == ST_DATA) && bit_end_c && (n_q != N_W'(DBIT - 1));

    uart_tx_shift #(.DBIT(DBIT)) u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (load_c),
        .shift     (shift_c),
        .data_in   (tx_data),
        .par_odd   (par_odd),
        .lsb_next_c(lsb_next_c),
        .par_bit   (par_bit)
    );

    // Next-state and next-output logic; tx is computed for the state being entered.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        tx_d      = tx_q;
        baud_en_d = baud_en_q;
        tx_done_d = 1'b0;
        cfg_err_d = 1'b0;
        dvsr_d    = dvsr_q;
        par_en_d  = par_en_q;

        if (cfg_wr) begin
            if (state_q == ST_IDLE) dvsr_d = cfg_dvsr;
            else                    cfg_err_d = 1'b1;
        end

        if ((state_q != ST_IDLE) && tick_c) begin
            s_d = bit_end_c ? '0 : s_q + S_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                tx_d      = 1'b1;
                baud_en_d = 1'b0;
                if (tx_valid) begin
                    par_en_d  = par_en;
                    state_d   = ST_START;
                    s_d       = '0;
                    n_d       = '0;
                    tx_d      = 1'b0;
                    baud_en_d = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end_c) begin
                    state_d = ST_DATA;
                    tx_d    = lsb_next_c;
                end
            end
            ST_DATA: begin
                if (bit_end_c) begin
                    if (n_q == N_W'(DBIT - 1)) begin
                        n_d     = '0;
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                        tx_d    = par_en_q ? par_bit : 1'b1;
                    end else begin
                        n_d  = n_q + N_W'(1);
                        tx_d = lsb_next_c;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end_c) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end_c) begin
                    if (n_q == N_W'(STOP_BITS - 1)) begin
                        n_d       = '0;
                        state_d   = ST_IDLE;
                        baud_en_d = 1'b0;
                        tx_done_d = 1'b1;
                    end else begin
                        n_d = n_q + N_W'(1);
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                tx_d      = 1'b1;
                baud_en_d = 1'b0;
            end
        endcase

        tx_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            n_q        <= '0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
            baud_en_q  <= 1'b0;
            en_prev_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
            dvsr_q     <= DVSR_W'(DVSR_RST);
            par_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            n_q        <= n_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
            baud_en_q  <= baud_en_d;
            en_prev_q  <= baud_en_q;
            tx_done_q  <= tx_done_d;
            cfg_err_q  <= cfg_err_d;
            dvsr_q     <= dvsr_d;
            par_en_q   <= par_en_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = tx_ready_q;
    assign baud_en  = baud_en_q;
    assign tx_done  = tx_done_q;
    assign cfg_err  = cfg_err_q;
    assign dvsr     = dvsr_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Testbench for uart_tx_ctrl: frame-level reference model plus directed
// literal checks and randomized frames.
module tb_uart_tx_ctrl;

    localparam int unsigned SBT = 16;
    localparam int unsigned DVR = 3;

    logic        clk;
    logic        rst;
    logic [15:0] cfg_dvsr;
    logic        cfg_wr;
    logic        cfg_err;
    logic [15:0] dvsr;
    logic        baud_en;
    logic        baud_tick;
    logic        par_en;
    logic        par_odd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_done;
    logic        tx;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;
    time t_hs;

    uart_tx_ctrl #(.DBIT(8), .SB_TICK(SBT), .STOP_BITS(1), .DVSR_RST(DVR)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_dvsr (cfg_dvsr),
        .cfg_wr   (cfg_wr),
        .cfg_err  (cfg_err),
        .dvsr     (dvsr),
        .baud_en  (baud_en),
        .baud_tick(baud_tick),
        .par_en   (par_en),
        .par_odd  (par_odd),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .tx       (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud generator stand-in: tick every dvsr+1 clocks while enabled,
    // tick level frozen while disabled.
    logic [15:0] bg_cnt;
    always @(posedge clk) begin
        if (rst) begin
            bg_cnt    <= '0;
            baud_tick <= 1'b0;
        end else if (!baud_en) begin
            bg_cnt <= '0;
        end else if (bg_cnt >= dvsr) begin
            bg_cnt    <= '0;
            baud_tick <= 1'b1;
        end else begin
            bg_cnt    <= bg_cnt + 16'd1;
            baud_tick <= 1'b0;
        end
    end

    // Reference model: a frame is a list of bits; the line shows bit
    // (qualified ticks since start / SBT) until all bits have elapsed.
    logic        m_busy = 0, m_tx = 1, m_en = 0, m_done = 0, m_ready = 1, m_err = 0, m_en_prev = 0;
    logic [15:0] m_dvsr = 16'(DVR);
    logic        m_bits [0:15];
    int          m_nbits = 0;
    int          m_ticks = 0;

    always @(posedge clk) begin : model
        bit q;
        int k;
        if (rst) begin
            m_busy = 0; m_tx = 1; m_en = 0; m_done = 0; m_ready = 1; m_err = 0;
            m_en_prev = 0; m_ticks = 0; m_dvsr = 16'(DVR);
        end else begin
            q = baud_tick && m_en_prev;
            m_en_prev = m_en;
            m_done = 0;
            m_err  = 0;
            if (cfg_wr) begin
                if (!m_busy) m_dvsr = cfg_dvsr;
                else         m_err  = 1;
            end
            if (!m_busy) begin
                if (tx_valid) begin
                    m_bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) m_bits[1+i] = tx_data[i];
                    k = 9;
                    if (par_en) begin
                        m_bits[k] = (^tx_data) ^ par_odd;
                        k++;
                    end
                    m_bits[k] = 1'b1;
                    m_nbits = k + 1;
                    m_busy = 1; m_ticks = 0; m_tx = 0; m_en = 1;
                end
            end else if (q) begin
                m_ticks++;
                if (m_ticks == m_nbits * SBT) begin
                    m_busy = 0; m_en = 0; m_done = 1; m_tx = 1;
                end else begin
                    m_tx = m_bits[m_ticks / SBT];
                end
            end
            m_ready = !m_busy;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("tx",       16'(tx),       16'(m_tx));
            check("baud_en",  16'(baud_en),  16'(m_en));
            check("tx_ready", 16'(tx_ready), 16'(m_ready));
            check("tx_done",  16'(tx_done),  16'(m_done));
            check("cfg_err",  16'(cfg_err),  16'(m_err));
            check("dvsr",     dvsr,          m_dvsr);
        end
    end

    // Present a byte and wait for the handshake edge; returns 1 ns after it.
    task automatic send(input logic [7:0] d, input logic pe, input logic po, input bit hold);
        bit got = 0;
        tx_data = d; par_en = pe; par_odd = po; tx_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (tx_ready) begin got = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL handshake: tx_ready never seen, expected within 3000 cycles");
        end
        @(posedge clk);
        t_hs = $time;
        #1;
        cfg_wr = 1'b0;
        if (!hold) begin
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
            par_en   = 1'($urandom);
            par_odd  = 1'($urandom);
        end
    endtask

    // Returns at the negedge where tx_done is high.
    task automatic wait_done();
        bit got = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (tx_done) begin got = 1; break; end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout: tx_done not seen, expected within 3000 cycles");
        end
    endtask

    // Sample each bit near its centre: start bit is 65 clk, later bits 64.
    task automatic sample_bits(input int nb, input logic [15:0] exp_bits, input string name);
        repeat (33) @(negedge clk);
        for (int k = 0; k < nb; k++) begin
            check(name, 16'(tx), 16'(exp_bits[k]));
            if (k != nb - 1) repeat (64) @(negedge clk);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len, cnt;
        logic [15:0] pat;
        rst = 1'b1; cfg_dvsr = '0; cfg_wr = 1'b0; par_en = 1'b0; par_odd = 1'b0;
        tx_data = '0; tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        check("rst_tx", 16'(tx), 16'd1);
        check("rst_ready", 16'(tx_ready), 16'd1);
        check("rst_baud_en", 16'(baud_en), 16'd0);
        check("rst_done", 16'(tx_done), 16'd0);
        check("rst_cfg_err", 16'(cfg_err), 16'd0);
        check("rst_dvsr", dvsr, 16'd3);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("idle_tx", 16'(tx), 16'd1);
        check("idle_baud_en", 16'(baud_en), 16'd0);

        // 8'hA5 without parity: 0,1,0,1,0,0,1,0,1,1
        send(8'hA5, 1'b0, 1'b0, 0);
        pat = 16'b0000_0011_0100_1010;
        sample_bits(10, pat, "a5_bit");
        wait_done();
        len = int'(($time - t_hs) / 10);
        check("a5_frame_len_ok", 16'((len >= 636 && len <= 646) ? 1 : 0), 16'd1);
        repeat (5) @(negedge clk);

        // 8'h07 even parity -> parity bit 1; odd -> 0
        send(8'h07, 1'b1, 1'b0, 0);
        pat = 16'b0000_0110_0000_1110;
        sample_bits(11, pat, "07_even_bit");
        wait_done();
        repeat (3) @(negedge clk);
        send(8'h07, 1'b1, 1'b1, 0);
        pat = 16'b0000_0100_0000_1110;
        sample_bits(11, pat, "07_odd_bit");
        wait_done();
        repeat (3) @(negedge clk);

        // Back-to-back with tx_valid held
        send(8'h00, 1'b0, 1'b0, 1);
        tx_data = 8'hFF;
        wait_done();
        check("b2b_ready_at_done", 16'(tx_ready), 16'd1);
        @(negedge clk);
        check("b2b_start_tx", 16'(tx), 16'd0);
        check("b2b_baud_en", 16'(baud_en), 16'd1);
        tx_valid = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);

        // Divisor write while busy is rejected, in IDLE it takes effect
        send(8'h55, 1'b0, 1'b0, 0);
        repeat (100) @(negedge clk);
        cfg_dvsr = 16'd7; cfg_wr = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0;
        check("busy_cfg_err", 16'(cfg_err), 16'd1);
        check("busy_dvsr", dvsr, 16'd3);
        wait_done();
        @(negedge clk);
        cfg_dvsr = 16'd7; cfg_wr = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0;
        check("idle_dvsr", dvsr, 16'd7);
        send(8'h55, 1'b0, 1'b0, 0);
        cnt = 0;
        while (tx == 1'b0 && cnt < 1000) begin @(negedge clk); cnt++; end
        cnt = 0;
        while (tx == 1'b1 && cnt < 1000) begin @(negedge clk); cnt++; end
        check("slow_bit_len", 16'(cnt), 16'd128);
        wait_done();
        @(negedge clk);
        cfg_dvsr = 16'd3; cfg_wr = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0;

        // Reset during data bit 4 abandons the frame
        send(8'hC3, 1'b1, 1'b0, 0);
        repeat (33 + 64 * 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_tx", 16'(tx), 16'd1);
        check("mid_rst_baud_en", 16'(baud_en), 16'd0);
        check("mid_rst_ready", 16'(tx_ready), 16'd1);
        repeat (200) @(negedge clk);
        send(8'h3C, 1'b0, 1'b0, 0);
        wait_done();

        // Randomized frames, divisor changes and rejected writes
        for (int f = 0; f < 25; f++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            if ($urandom_range(0, 2) == 0) begin
                cfg_dvsr = 16'($urandom_range(0, 3)); cfg_wr = 1'b1;
                if ($urandom_range(0, 1) == 0) begin
                    @(negedge clk);
                    cfg_wr = 1'b0;
                end
            end
            send(8'($urandom), 1'($urandom), 1'($urandom), 0);
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 50)) @(negedge clk);
                cfg_dvsr = 16'($urandom); cfg_wr = 1'b1;
                @(negedge clk);
                cfg_wr = 1'b0;
            end
            wait_done();
        end

        repeat (10) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
